// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame size and parity helper,
// common to the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_BIT  = 3'd1,
      DATA_BITS  = 3'd2,
      STOP_BIT   = 3'd3,
      PARITY_BIT = 3'd4,
      GUARD      = 3'd5
   } uart_state_e;

   // Start + 8 data + stop + parity; the guard bit is idle time, not frame content.
   localparam int unsigned FRAME_BITS = 32'd11;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKs_per_bit-1 and flags the last cycle
// of each serial bit. restart holds the count at zero.
module uart_bit_timer #(
   parameter int CLKs_per_bit = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic last
);

   localparam logic [7:0] LAST_COUNT = 8'(CLKs_per_bit - 1);

   logic [7:0] count_r;

   // Wrapping bit-period counter
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         count_r <= 8'd0;
      end else if (count_r == LAST_COUNT) begin
         count_r <= 8'd0;
      end else begin
         count_r <= count_r + 8'd1;
      end
   end

   assign last = (count_r == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, stop, odd parity, guard.
// Define UART_TX_HOLD_EN to add a one-entry hold buffer for back-to-back frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKs_per_bit = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       data_out,
   output logic       busy,
   output logic       done
);

   uart_state_e state_r, state_next_s;
   logic [7:0]  shift_r, shift_next_s;
   logic [2:0]  bit_idx_r, bit_idx_next_s;
   logic        parity_r, parity_next_s;
   logic        data_out_r, busy_r, done_r, tx_ready_r;
   logic        line_s, ready_next_s;
   logic        bit_last_s, accept_s, start_s, guard_end_s;
   logic [7:0]  start_byte_s;

   uart_bit_timer #(.CLKs_per_bit(CLKs_per_bit)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (state_r == IDLE),
      .last    (bit_last_s)
   );

   assign accept_s    = tx_valid && tx_ready_r;
   assign guard_end_s = (state_r == GUARD) && bit_last_s;

`ifdef UART_TX_HOLD_EN
   logic [7:0] hold_r;
   logic       hold_full_r, hold_full_next_s, fill_s, free_s;

   // A held byte, or one accepted during the last guard cycle, starts with no idle gap.
   assign start_s      = ((state_r == IDLE) && accept_s) || (guard_end_s && (hold_full_r || accept_s));
   assign start_byte_s = hold_full_r ? hold_r : tx_data;
   assign fill_s       = accept_s && !start_s;
   assign free_s       = guard_end_s && hold_full_r;

   // Fill wins over free so a same-cycle refill keeps the buffer full
   always_comb begin
      if (fill_s) begin
         hold_full_next_s = 1'b1;
      end else if (free_s) begin
         hold_full_next_s = 1'b0;
      end else begin
         hold_full_next_s = hold_full_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_r      <= 8'd0;
         hold_full_r <= 1'b0;
      end else begin
         hold_full_r <= hold_full_next_s;
         if (fill_s) begin
            hold_r <= tx_data;
         end
      end
   end

   assign ready_next_s = !hold_full_next_s;
`else
   assign start_s      = (state_r == IDLE) && accept_s;
   assign start_byte_s = tx_data;
   assign ready_next_s = (state_next_s == IDLE);
`endif

   // Next-state, shift register and parity latch
   always_comb begin
      state_next_s   = state_r;
      shift_next_s   = shift_r;
      bit_idx_next_s = bit_idx_r;
      parity_next_s  = parity_r;
      case (state_r)
         IDLE, GUARD: begin
            if (start_s) begin
               state_next_s   = START_BIT;
               shift_next_s   = start_byte_s;
               parity_next_s  = odd_parity(start_byte_s);
               bit_idx_next_s = 3'd0;
            end else if (state_r == GUARD && bit_last_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         START_BIT: begin
            if (bit_last_s) begin
               state_next_s   = DATA_BITS;
               bit_idx_next_s = 3'd0;
            end else begin
               state_next_s = START_BIT;
            end
         end
         DATA_BITS: begin
            if (bit_last_s && bit_idx_r == 3'd7) begin
               state_next_s = STOP_BIT;
            end else if (bit_last_s) begin
               bit_idx_next_s = bit_idx_r + 3'd1;
               shift_next_s   = {1'b0, shift_r[7:1]};
            end else begin
               state_next_s = DATA_BITS;
            end
         end
         STOP_BIT: begin
            if (bit_last_s) begin
               state_next_s = PARITY_BIT;
            end else begin
               state_next_s = STOP_BIT;
            end
         end
         PARITY_BIT: begin
            if (bit_last_s) begin
               state_next_s = GUARD;
            end else begin
               state_next_s = PARITY_BIT;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Line level for the coming cycle, so data_out can be registered
   always_comb begin
      line_s = 1'b1;
      case (state_next_s)
         START_BIT:  line_s = 1'b0;
         DATA_BITS:  line_s = shift_next_s[0];
         PARITY_BIT: line_s = parity_next_s;
         default:    line_s = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         shift_r    <= 8'd0;
         bit_idx_r  <= 3'd0;
         parity_r   <= 1'b0;
         data_out_r <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         tx_ready_r <= 1'b1;
      end else begin
         state_r    <= state_next_s;
         shift_r    <= shift_next_s;
         bit_idx_r  <= bit_idx_next_s;
         parity_r   <= parity_next_s;
         data_out_r <= line_s;
         busy_r     <= (state_next_s != IDLE);
         done_r     <= guard_end_s;
         tx_ready_r <= ready_next_s;
      end
   end

   assign tx_ready = tx_ready_r;
   assign data_out = data_out_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule
